// File: rtl/tap_route_pkg.sv
// Shared TAP state encoding for the pad-ring test-access controller.
// Codes are the ones seen on the observation pads by the downstream IR/DR decode.
package tap_route_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    TLR = 4'hF,
    RTI = 4'hC,
    SDS = 4'h7,
    CDR = 4'h6,
    SDR = 4'h2,
    E1D = 4'h1,
    PDR = 4'h3,
    E2D = 4'h0,
    UDR = 4'h5,
    SIS = 4'h4,
    CIR = 4'hE,
    SIR = 4'hA,
    E1I = 4'h9,
    PIR = 4'hB,
    E2I = 4'h8,
    UIR = 4'hD
  } tap_state_e;

  localparam tap_state_e TLR_CODE = TLR;

endpackage

// File: rtl/tap_route_next_state.sv
// Pure combinational TAP next-state function: (state, tms) -> state.
// Unlisted codes cannot occur; if one ever does, it falls back to Test-Logic-Reset.
module tap_next_state
  import tap_route_pkg::*;
(
  input  tap_state_e state,
  input  logic       tms,
  output tap_state_e next
);

  // TAP transition table
  always_comb begin
    next = TLR_CODE;
    case (state)
      TLR: next = tms ? TLR : RTI;
      RTI: next = tms ? SDS : RTI;
      SDS: next = tms ? SIS : CDR;
      CDR: next = tms ? E1D : SDR;
      SDR: next = tms ? E1D : SDR;
      E1D: next = tms ? UDR : PDR;
      PDR: next = tms ? E2D : PDR;
      E2D: next = tms ? UDR : SDR;
      UDR: next = tms ? SDS : RTI;
      SIS: next = tms ? TLR : CIR;
      CIR: next = tms ? E1I : SIR;
      SIR: next = tms ? E1I : SIR;
      E1I: next = tms ? UIR : PIR;
      PIR: next = tms ? E2I : PIR;
      E2I: next = tms ? UIR : SIR;
      UIR: next = tms ? SDS : RTI;
      default: next = TLR_CODE;
    endcase
  end

endmodule

// File: rtl/tap_route.sv
// IEEE 1149.1 TAP controller at the pad ring; exports its state code on four pads.
// Pads are driven straight from the state register, so TMS never reaches them combinationally.
module tap_route
  import tap_route_pkg::*;
(
  input  logic GCLK_Pad,
  input  logic TRST_Pad,
  input  logic TMS_Pad,
  output logic state_obs0_Pad,
  output logic state_obs1_Pad,
  output logic state_obs2_Pad,
  output logic state_obs3_Pad
);

  tap_state_e state_r;
  tap_state_e next_s;

  tap_next_state u_next (
    .state (state_r),
    .tms   (TMS_Pad),
    .next  (next_s)
  );

  // State register; TRST forces TLR immediately and wins over a coincident edge
  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      state_r <= TLR_CODE;
    end else begin
      state_r <= next_s;
    end
  end

  assign state_obs0_Pad = state_r[0];
  assign state_obs1_Pad = state_r[1];
  assign state_obs2_Pad = state_r[2];
  assign state_obs3_Pad = state_r[3];

endmodule

// File: tb/tb_tap_route.sv
// Directed self-checking bench for tap_route: expected pad codes are queued when TMS
// is driven and compared after the following rising edge.
`timescale 1ns/1ps
module tb_tap_route;

  logic gclk;
  logic trst;
  logic tms;
  logic clk_en;
  logic obs0, obs1, obs2, obs3;
  logic [3:0] obs;

  int checks;
  int errors;
  logic [3:0] exp_q[$];

  assign obs = {obs3, obs2, obs1, obs0};

  tap_route dut (
    .GCLK_Pad       (gclk),
    .TRST_Pad       (trst),
    .TMS_Pad        (tms),
    .state_obs0_Pad (obs0),
    .state_obs1_Pad (obs1),
    .state_obs2_Pad (obs2),
    .state_obs3_Pad (obs3)
  );

  always #5 gclk = clk_en ? ~gclk : gclk;

  task automatic check(input string tag);
    logic [3:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic t, input logic [3:0] code);
    @(negedge gclk);
    tms = t;
    exp_q.push_back(code);
    @(posedge gclk);
    #1;
    check(tag);
  endtask

  // Element i (0-first) uses tms_bits[n-1-i] and codes[4*(n-1-i) +: 4]
  task automatic seq(input string tag, input logic [15:0] tms_bits,
                     input logic [63:0] codes, input int n);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s[%0d]", tag, i), tms_bits[n-1-i], codes[4*(n-1-i) +: 4]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    gclk = 1'b0;
    clk_en = 1'b0;
    tms = 1'b0;
    trst = 1'b0;

    // Reset pulse with no clock running
    #1;
    trst = 1'b1;
    #0.001;
    exp_q.push_back(4'hF);
    check("rst_async");
    #0.001;
    trst = 1'b0;
    #1;
    exp_q.push_back(4'hF);
    check("rst_hold");

    clk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("rti_idle[%0d]", i), 1'b0, 4'hC);
    end

    // Back to TLR via TMS=1
    seq("to_tlr", 16'b11111, 64'h74FFF, 5);

    seq("dr_path", 16'b010010110, 64'hC7621305C, 9);

    seq("ir_path", 16'b110001011, 64'h74EAA9B8D, 9);

    // UIR -> SIR
    seq("to_sir", 16'b1100, 64'h74EA, 4);
    seq("escape", 16'b111111, 64'h9D74FF, 6);

    // Into SDR then async reset between edges
    seq("to_sdr", 16'b0100, 64'hC762, 4);
    #2;
    trst = 1'b1;
    #1;
    exp_q.push_back(4'hF);
    check("rst_mid_sdr");
    @(negedge gclk);
    trst = 1'b0;
    exp_q.push_back(4'hF);
    #0.5;
    check("rst_mid_release");
    step("after_mid_rst", 1'b0, 4'hC);

    // Reset held across a rising edge
    seq("to_sds", 16'b1, 64'h7, 1);
    @(negedge gclk);
    trst = 1'b1;
    tms = 1'b0;
    @(posedge gclk);
    #1;
    exp_q.push_back(4'hF);
    check("collision_edge");
    @(posedge gclk);
    #1;
    exp_q.push_back(4'hF);
    check("collision_edge2");
    @(negedge gclk);
    trst = 1'b0;
    step("after_collision", 1'b0, 4'hC);
    step("after_collision2", 1'b1, 4'h7);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover scoreboard entries=%0d", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_route.md
Name: tap_route

Overview:
- IEEE 1149.1 TAP controller state machine: 16 states, stepped by TMS on each rising GCLK_Pad edge.
- Forced to Test-Logic-Reset by TRST_Pad.
- Current state is exported as a 4-bit code on four single-bit observation pads.
- Sits at the chip pad ring as the test-access routing/control point; downstream IR/DR logic decodes the state code.

Parameters:
- None. State code width is fixed at 4.

Ports:
- GCLK_Pad  input  1  sole clock; all state updates on rising edge
- TRST_Pad  input  1  asynchronous active-high reset; forces Test-Logic-Reset
- TMS_Pad  input  1  test mode select; sampled on rising GCLK_Pad
- state_obs0_Pad  output  1  state code bit 0 (LSB)
- state_obs1_Pad  output  1  state code bit 1
- state_obs2_Pad  output  1  state code bit 2
- state_obs3_Pad  output  1  state code bit 3 (MSB)

Behaviour:
- One clock, GCLK_Pad. Reset TRST_Pad is asynchronous and active-high.
- While TRST_Pad=1, state is TLR (code 0xF) immediately, regardless of the clock.
- On TRST_Pad deassertion, state holds TLR until the next rising GCLK_Pad edge.
- Outputs are driven directly from the state register: no combinational path from TMS_Pad, and no extra latency. Reset value of all outputs is 1 (0xF).
- Next state is taken at each rising GCLK_Pad edge from the current state and TMS_Pad. Format: state(code) TMS=0 -> / TMS=1 ->
  - TLR(F): RTI / TLR
  - RTI(C): RTI / SDS
  - SDS(7): CDR / SIS
  - CDR(6): SDR / E1D
  - SDR(2): SDR / E1D
  - E1D(1): PDR / UDR
  - PDR(3): PDR / E2D
  - E2D(0): SDR / UDR
  - UDR(5): RTI / SDS
  - SIS(4): CIR / TLR
  - CIR(E): SIR / E1I
  - SIR(A): SIR / E1I
  - E1I(9): PIR / UIR
  - PIR(B): PIR / E2I
  - E2I(8): SIR / UIR
  - UIR(D): RTI / SDS
- Any state code not listed must never occur. Treat it defensively as a next state of TLR.
- From any state, five consecutive clocks with TMS_Pad=1 reach TLR.
- TMS_Pad must be stable around the rising edge (setup/hold). A TMS pulse that falls before the edge is sampled as 0.
- TRST_Pad asserted mid-sequence (e.g. in SDR) aborts the sequence with no further effect.
- TRST_Pad coincident with a clock edge: reset wins, state = TLR.
- There is no power-on state other than via TRST_Pad. Integration must pulse TRST_Pad at startup.

Decomposition:
- Shared package holds:
  - the 4-bit state enum with the codes above;
  - the state-width constant (4);
  - the TLR reset-code constant.
- A single module is sufficient.
- Optional sub-module tap_next_state: pure combinational next-state function (state, tms) -> state, reusable by the verification model.

Test Plan:
- Reset: pulse TRST_Pad=1 for 2 ps with no clock -> obs[3:0]=0xF at once. Then 20 clocks with TMS=0 -> 0xC after the first edge, stays 0xC.
- DR path: from TLR, TMS sequence 0,1,0,0,1,0,1,1,0 -> codes C,7,6,2,1,3,0,5,C.
- IR path: from RTI, TMS 1,1,0,0,0,1,0,1,1 -> codes 7,4,E,A,A,9,B,8,D.
- TMS-high escape: from SIR (0xA), five clocks TMS=1 -> 9,D,7,4,F; a sixth TMS=1 clock stays F.
- Async reset mid-op: in SDR (0x2), raise TRST_Pad between edges -> 0xF before the next edge. Next edge with TMS=0 after release -> 0xC.
- Reset/edge collision: TRST_Pad=1 held across a rising edge with TMS=0 -> remains 0xF while asserted.
